wb_stage: RTL and testbench

//  Writeback end of the ME/WB pipeline interface: consumes the registered ME/WB outputs, extracts and extends load data,

---
 rtl/wb_stage_pkg.sv | 29 ++
 rtl/wb_stage_reg_file.sv | 39 +++
 rtl/wb_stage.sv | 128 ++++++++++++
 tb/tb_wb_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared RV32I definitions for the writeback stage: opcode and load funct3 codes,
// plus the predicate for opcodes that produce a register result.
package wb_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  function automatic logic is_writing(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_OP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_writing = 1'b1;
      default:                                                 is_writing = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_stage_reg_file.sv
// Integer register file: 32 x XLEN, x0 hardwired to zero, one write port and two
// asynchronous read ports that see the in-flight write in the same cycle.
module reg_file #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [1:31];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr, input logic wen,
                                                input logic [4:0] wa, input logic [XLEN-1:0] wd,
                                                input logic [XLEN-1:0] stored);
    if (addr == 5'd0)             read_port = '0;
    else if (wen && wa == addr)   read_port = wd;
    else                          read_port = stored;
  endfunction

  // Index x0 safely: its storage does not exist, read_port masks it to zero anyway.
  assign rdata1 = read_port(raddr1, we, waddr, wdata, (raddr1 == 5'd0) ? '0 : regs[raddr1]);
  assign rdata2 = read_port(raddr2, we, waddr, wdata, (raddr2 == 5'd0) ? '0 : regs[raddr2]);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: load extraction, result select, register-file commit with bypassed
// decode reads, retired-instruction counter and a one-cycle-delayed commit trace.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [6:0]       opcode_in,
  input  logic [2:0]       funct3_in,
  input  logic [4:0]       rd_in,
  input  logic [XLEN-1:0]  alu_res_in,
  input  logic [XLEN-1:0]  mem_res_in,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             load_misalign,
  output logic [CNT_W-1:0] retired,
  output logic             trace_valid,
  output logic [XLEN-1:0]  trace_pc,
  output logic [4:0]       trace_rd,
  output logic [XLEN-1:0]  trace_data
);

  function automatic logic [XLEN-1:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   extract_load = {{(XLEN-8){b[7]}}, b};
      F3_LBU:  extract_load = {{(XLEN-8){1'b0}}, b};
      F3_LH:   extract_load = {{(XLEN-16){h[15]}}, h};
      F3_LHU:  extract_load = {{(XLEN-16){1'b0}}, h};
      default: extract_load = word;
    endcase
  endfunction

  // Reserved load sizes (funct3 3/6/7) fault the same way as a misaligned address.
  function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: load_bad = 1'b0;
      F3_LH, F3_LHU: load_bad = off[0];
      F3_LW:         load_bad = (off != 2'd0);
      default:       load_bad = 1'b1;
    endcase
  endfunction

  logic            is_load;
  logic            fault;
  logic [XLEN-1:0] result;

  always_comb begin
    is_load = (opcode_in == OP_LOAD);
    fault   = valid_in & is_load & load_bad(funct3_in, alu_res_in[1:0]);
    case (opcode_in)
      OP_LOAD:         result = extract_load(funct3_in, alu_res_in[1:0], mem_res_in);
      OP_JAL, OP_JALR: result = pc_in + XLEN'(4);
      default:         result = alu_res_in;
    endcase
  end

  assign wb_en   = valid_in & is_writing(opcode_in) & (rd_in != 5'd0) & ~fault;
  assign wb_rd   = rd_in;
  assign wb_data = result;

  reg_file #(.XLEN(XLEN)) u_reg_file (
    .clock  (clock),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  logic             misalign_p1;
  logic [CNT_W-1:0] retired_p1;
  logic             vld_p1;
  logic [XLEN-1:0]  pc_p1;
  logic [4:0]       rd_p1;
  logic [XLEN-1:0]  data_p1;

  // Stage p1: status, counter and commit trace, one edge after the commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      misalign_p1 <= 1'b0;
      retired_p1  <= '0;
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rd_p1       <= '0;
      data_p1     <= '0;
    end else begin
      misalign_p1 <= fault;
      if (valid_in) retired_p1 <= retired_p1 + CNT_W'(1);
      vld_p1      <= wb_en;
      if (wb_en) begin
        pc_p1   <= pc_in;
        rd_p1   <= wb_rd;
        data_p1 <= wb_data;
      end
    end
  end

  assign load_misalign = misalign_p1;
  assign retired       = retired_p1;
  assign trace_valid   = vld_p1;
  assign trace_pc      = pc_p1;
  assign trace_rd      = rd_p1;
  assign trace_data    = data_p1;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: behavioural model with per-cycle comparison plus directed
// vectors with hand-computed expectations.
module tb_wb_stage;

  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33, LUI = 7'h37,
                         AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BRANCH = 7'h63, SYSTEM = 7'h73;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic [6:0]  opcode_in = OP;
  logic [2:0]  funct3_in = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] alu_res_in = '0;
  logic [31:0] mem_res_in = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data, rs2_data, wb_data, trace_pc, trace_data;
  logic        wb_en, load_misalign, trace_valid;
  logic [4:0]  wb_rd, trace_rd;
  logic [63:0] retired;
  logic [31:0] s_rs1_data, s_rs2_data, s_wb_data, s_trace_pc, s_trace_data;
  logic        s_wb_en, s_load_misalign, s_trace_valid;
  logic [4:0]  s_wb_rd, s_trace_rd;
  logic [2:0]  s_retired;

  always #5 clock = ~clock;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .opcode_in(opcode_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .alu_res_in(alu_res_in), .mem_res_in(mem_res_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .load_misalign(load_misalign),
    .retired(retired), .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_rd(trace_rd),
    .trace_data(trace_data)
  );

  // Narrow-counter instance so the wrap to zero is reachable in a few cycles.
  wb_stage #(.XLEN(32), .CNT_W(3)) dut_small (
    .clock(clock), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .opcode_in(opcode_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .alu_res_in(alu_res_in), .mem_res_in(mem_res_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
    .wb_en(s_wb_en), .wb_rd(s_wb_rd), .wb_data(s_wb_data), .load_misalign(s_load_misalign),
    .retired(s_retired), .trace_valid(s_trace_valid), .trace_pc(s_trace_pc), .trace_rd(s_trace_rd),
    .trace_data(s_trace_data)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model state
  logic [31:0] m_rf [32];
  logic [63:0] m_ret;
  logic        m_mis, m_tv;
  logic [31:0] m_tpc, m_tdata;
  logic [4:0]  m_trd;
  bit          model_live = 0;

  function automatic void model_commit(output logic en, output logic [31:0] data, output logic flt);
    int unsigned off, b, h;
    bit writes, bad;
    off = alu_res_in % 4;
    b = (mem_res_in >> (8 * off)) & 32'hFF;
    h = (mem_res_in >> (16 * (off / 2))) & 32'hFFFF;
    writes = (opcode_in inside {LOAD, OPIMM, OP, LUI, AUIPC, JAL, JALR});
    bad = 0;
    data = alu_res_in;
    if (opcode_in == LOAD) begin
      case (funct3_in)
        3'd0: data = (b < 128) ? b : b + 32'hFFFFFF00;
        3'd4: data = b;
        3'd1: begin bad = (off % 2 != 0); data = (h < 32768) ? h : h + 32'hFFFF0000; end
        3'd5: begin bad = (off % 2 != 0); data = h; end
        3'd2: begin bad = (off != 0); data = mem_res_in; end
        default: bad = 1;
      endcase
    end else if (opcode_in == JAL || opcode_in == JALR) begin
      data = pc_in + 32'd4;
    end
    flt = valid_in && opcode_in == LOAD && bad;
    en = valid_in && writes && rd_in != 0 && !flt;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic en, input logic [31:0] d);
    if (a == 0) return 32'd0;
    if (en && rd_in == a) return d;
    return m_rf[a];
  endfunction

  always @(posedge clock) begin
    logic en, flt;
    logic [31:0] d;
    model_commit(en, d, flt);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_ret = '0; m_mis = 0; m_tv = 0; m_tpc = '0; m_trd = '0; m_tdata = '0;
      model_live = 1;
    end else begin
      if (valid_in) m_ret = m_ret + 1;
      m_mis = flt;
      m_tv = en;
      if (en) begin
        m_rf[rd_in] = d;
        m_tpc = pc_in; m_trd = rd_in; m_tdata = d;
      end
    end
  end

  always @(negedge clock) begin
    logic en, flt;
    logic [31:0] d;
    if (model_live) begin
      model_commit(en, d, flt);
      check("wb_en", wb_en, en);
      if (en) begin
        check("wb_rd", wb_rd, rd_in);
        check("wb_data", wb_data, d);
      end
      check("rs1_data", rs1_data, model_read(rs1_addr, en, d));
      check("rs2_data", rs2_data, model_read(rs2_addr, en, d));
      check("load_misalign", load_misalign, m_mis);
      check("retired", retired, m_ret);
      check("retired_small", s_retired, m_ret[2:0]);
      check("trace_valid", trace_valid, m_tv);
      check("trace_pc", trace_pc, m_tpc);
      check("trace_rd", trace_rd, m_trd);
      check("trace_data", trace_data, m_tdata);
    end
  end

  task automatic cyc(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                     input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem,
                     input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clock);
    #1;
    valid_in = v; opcode_in = op; funct3_in = f3; rd_in = rd;
    pc_in = pc; alu_res_in = alu; mem_res_in = mem; rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic idle(input logic [4:0] a1);
    cyc(1'b0, OP, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, a1, 5'd0);
  endtask

  logic [63:0] base;

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state: every register reads zero
    for (int i = 1; i < 32; i++) begin
      cyc(1'b0, OP, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(32 - i));
      @(negedge clock);
      check("reset_reg", rs1_data, 32'h0);
    end
    check("reset_retired", retired, 64'h0);
    check("reset_trace_valid", trace_valid, 1'b0);

    // Write to x0 is dropped
    cyc(1'b1, OP, 3'd0, 5'd0, 32'h100, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
    @(negedge clock);
    check("x0_wb_en", wb_en, 1'b0);
    check("x0_read", rs1_data, 32'h0);
    idle(5'd0);
    @(negedge clock);
    check("x0_read_after", rs1_data, 32'h0);

    // Same-cycle bypass then stored value
    cyc(1'b1, OP, 3'd0, 5'd5, 32'h104, 32'h12345678, 32'h0, 5'd5, 5'd0);
    @(negedge clock);
    check("bypass_rs1", rs1_data, 32'h12345678);
    idle(5'd5);
    @(negedge clock);
    check("stored_rs1", rs1_data, 32'h12345678);
    check("trace_valid_1", trace_valid, 1'b1);
    check("trace_rd_5", trace_rd, 5'd5);
    check("trace_pc_104", trace_pc, 32'h104);

    // Load extraction
    cyc(1'b1, LOAD, 3'd0, 5'd10, 32'h200, 32'h2003, 32'h80FF7F01, 5'd10, 5'd0);
    @(negedge clock); check("lb_off3", wb_data, 32'hFFFFFF80); check("lb_en", wb_en, 1'b1);
    cyc(1'b1, LOAD, 3'd4, 5'd11, 32'h204, 32'h2003, 32'h80FF7F01, 5'd11, 5'd0);
    @(negedge clock); check("lbu_off3", wb_data, 32'h00000080);
    cyc(1'b1, LOAD, 3'd1, 5'd12, 32'h208, 32'h2002, 32'h80FF7F01, 5'd12, 5'd0);
    @(negedge clock); check("lh_off2", wb_data, 32'hFFFF80FF);
    cyc(1'b1, LOAD, 3'd5, 5'd13, 32'h20C, 32'h2000, 32'h80FF7F01, 5'd13, 5'd0);
    @(negedge clock); check("lhu_off0", wb_data, 32'h00007F01);

    // Faulting loads
    cyc(1'b1, OP, 3'd0, 5'd7, 32'h210, 32'hA5A5A5A5, 32'h0, 5'd0, 5'd0);
    cyc(1'b1, LOAD, 3'd2, 5'd7, 32'h214, 32'h1002, 32'hDEADBEEF, 5'd7, 5'd0);
    @(negedge clock);
    check("lw_mis_wb_en", wb_en, 1'b0);
    check("lw_mis_no_bypass", rs1_data, 32'hA5A5A5A5);
    base = m_ret;
    idle(5'd7);
    @(negedge clock);
    check("lw_mis_pulse", load_misalign, 1'b1);
    check("lw_mis_retired", retired, base + 64'd1);
    check("lw_mis_x7", rs1_data, 32'hA5A5A5A5);
    idle(5'd7);
    @(negedge clock);
    check("lw_mis_pulse_end", load_misalign, 1'b0);
    cyc(1'b1, LOAD, 3'd3, 5'd7, 32'h218, 32'h1000, 32'hDEADBEEF, 5'd7, 5'd0);
    @(negedge clock);
    check("f3_3_wb_en", wb_en, 1'b0);
    idle(5'd7);
    @(negedge clock);
    check("f3_3_pulse", load_misalign, 1'b1);
    check("f3_3_x7", rs1_data, 32'hA5A5A5A5);

    // Jumps: link address wraps
    cyc(1'b1, OP, 3'd0, 5'd1, 32'h220, 32'h11, 32'h0, 5'd0, 5'd0);
    cyc(1'b1, JAL, 3'd0, 5'd1, 32'hFFFFFFFC, 32'h55, 32'h0, 5'd1, 5'd0);
    @(negedge clock); check("jal_wrap", wb_data, 32'h0);
    cyc(1'b1, JALR, 3'd0, 5'd2, 32'h100, 32'h55, 32'h0, 5'd1, 5'd2);
    @(negedge clock); check("jalr_link", wb_data, 32'h104);
    check("x1_after_jal", rs1_data, 32'h0);

    // Non-writing opcodes and idle slots
    cyc(1'b1, OP, 3'd0, 5'd9, 32'h230, 32'h99, 32'h0, 5'd0, 5'd0);
    base = m_ret + 1;
    cyc(1'b1, STORE, 3'd2, 5'd9, 32'h234, 32'h1, 32'h0, 5'd9, 5'd0);
    @(negedge clock); check("store_wb_en", wb_en, 1'b0);
    cyc(1'b1, BRANCH, 3'd0, 5'd9, 32'h238, 32'h2, 32'h0, 5'd9, 5'd0);
    @(negedge clock); check("branch_wb_en", wb_en, 1'b0);
    cyc(1'b0, OP, 3'd0, 5'd9, 32'h23C, 32'h3, 32'h0, 5'd9, 5'd0);
    @(negedge clock); check("invalid_wb_en", wb_en, 1'b0);
    idle(5'd9);
    @(negedge clock);
    check("x9_kept", rs1_data, 32'h99);
    check("store_branch_retired", retired, base + 64'd2);
    cyc(1'b1, LUI, 3'd0, 5'd20, 32'h240, 32'hABC00000, 32'h0, 5'd0, 5'd0);
    cyc(1'b1, AUIPC, 3'd0, 5'd21, 32'h244, 32'h1244, 32'h0, 5'd20, 5'd21);
    cyc(1'b1, SYSTEM, 3'd0, 5'd22, 32'h248, 32'h7, 32'h0, 5'd22, 5'd20);

    // Reset wins over a same-edge commit
    cyc(1'b1, OP, 3'd0, 5'd3, 32'h250, 32'h33, 32'h0, 5'd0, 5'd0);
    cyc(1'b1, OP, 3'd0, 5'd3, 32'h254, 32'h77, 32'h0, 5'd3, 5'd0);
    reset = 1'b1;
    idle(5'd3);
    reset = 1'b0;
    @(negedge clock);
    check("reset_x3", rs1_data, 32'h0);
    check("reset_trace_valid2", trace_valid, 1'b0);
    check("reset_retired2", retired, 64'h0);

    // Counter wrap on the 3-bit instance
    repeat (7) cyc(1'b1, STORE, 3'd2, 5'd0, 32'h300, 32'h0, 32'h0, 5'd0, 5'd0);
    idle(5'd0);
    @(negedge clock);
    check("small_at_max", s_retired, 3'd7);
    cyc(1'b1, STORE, 3'd2, 5'd0, 32'h300, 32'h0, 32'h0, 5'd0, 5'd0);
    idle(5'd0);
    @(negedge clock);
    check("small_wrapped", s_retired, 3'd0);
    check("wide_no_wrap", retired, 64'd8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
